// File: rtl/pc_ctrl_unit_if.sv
// Datapath-side bundle for the PC/branch unit: decoded instruction fields and flags in,
// PC, branch decision and status out.
interface pc_ctrl_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IMM_W  = 9,
  parameter int unsigned CNT_W  = 32
);
  logic              stall;
  logic [3:0]        opcode;
  logic [2:0]        cond;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] rs_data;
  logic [2:0]        flag_wen;
  logic              z_in;
  logic              n_in;
  logic              v_in;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              taken;
  logic [2:0]        flags;
  logic              hlt;
  logic [CNT_W-1:0]  icount;

  modport master (
    output stall, opcode, cond, imm, rs_data, flag_wen, z_in, n_in, v_in,
    input  pc, pc_plus, taken, flags, hlt, icount
  );

  modport slave (
    input  stall, opcode, cond, imm, rs_data, flag_wen, z_in, n_in, v_in,
    output pc, pc_plus, taken, flags, hlt, icount
  );
endinterface

// File: rtl/pc_ctrl_unit.sv
// Program counter, flag register, halt FSM and retired-instruction counter for the WISC core.
// Resolves B/BR against the registered Z/N/V flags and selects the next PC.
module pc_ctrl_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          IMM_W    = 9,
  parameter int unsigned          INC      = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  pc_ctrl_unit_if.slave bus
);
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        flags_q;
  logic              hlt_q;
  logic [CNT_W-1:0]  icount_q;

  logic              z_f, n_f, v_f;
  logic              cond_met;
  logic              is_b, is_br;
  logic              taken_c;
  logic              active;
  logic [ADDR_W-1:0] pc_plus_c;
  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] b_target;
  logic [ADDR_W-1:0] pc_next;

  assign z_f = flags_q[2];
  assign n_f = flags_q[1];
  assign v_f = flags_q[0];

  always_comb begin
    cond_met = 1'b0;
    unique case (bus.cond)
      3'b000: cond_met = !z_f;
      3'b001: cond_met = z_f;
      3'b010: cond_met = !z_f && !n_f;
      3'b011: cond_met = n_f;
      3'b100: cond_met = z_f || !n_f;
      3'b101: cond_met = z_f || n_f;
      3'b110: cond_met = v_f;
      3'b111: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  assign is_b      = (bus.opcode == OP_B);
  assign is_br     = (bus.opcode == OP_BR);
  assign taken_c   = (is_b || is_br) && cond_met && (state == RUN);
  assign active    = (state == RUN) && !bus.stall;
  assign pc_plus_c = pc_q + ADDR_W'(INC);
  assign imm_sext  = {{(ADDR_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  // Offset is in instruction words; the doubling and the add both wrap mod 2^ADDR_W.
  assign b_target  = pc_plus_c + {imm_sext[ADDR_W-2:0], 1'b0};

  always_comb begin
    pc_next = pc_plus_c;
    if (taken_c && is_b)
      pc_next = b_target;
    else if (taken_c && is_br)
      pc_next = bus.rs_data;
    else if (bus.opcode == OP_HLT)
      pc_next = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc_q     <= RESET_PC;
      flags_q  <= '0;
      hlt_q    <= 1'b0;
      icount_q <= '0;
    end else if (active) begin
      pc_q     <= pc_next;
      icount_q <= icount_q + 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (bus.flag_wen[i])
          flags_q[i] <= (i == 2) ? bus.z_in : (i == 1) ? bus.n_in : bus.v_in;
      end
      if (bus.opcode == OP_HLT) begin
        state <= HALTED;
        hlt_q <= 1'b1;
      end
    end
  end

  assign bus.pc      = pc_q;
  assign bus.pc_plus = pc_plus_c;
  assign bus.taken   = taken_c;
  assign bus.flags   = flags_q;
  assign bus.hlt     = hlt_q;
  assign bus.icount  = icount_q;
endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Directed bench for pc_ctrl_unit: sequencing, branch targets and wrap, condition codes,
// old-flag branch semantics, stalled halt and reset out of halt.
module tb_pc_ctrl_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_ctrl_unit_if #(.ADDR_W(16), .IMM_W(9), .CNT_W(32)) bus ();

  pc_ctrl_unit #(
    .ADDR_W(16), .IMM_W(9), .INC(2), .RESET_PC(16'h0000), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] c, input logic [8:0] im,
                       input logic [15:0] rs, input logic [2:0] wen,
                       input logic z, input logic n, input logic v);
    bus.opcode   = op;
    bus.cond     = c;
    bus.imm      = im;
    bus.rs_data  = rs;
    bus.flag_wen = wen;
    bus.z_in     = z;
    bus.n_in     = n;
    bus.v_in     = v;
  endtask

  // Expected taken per cond with flags Z=0 N=1 V=1.
  logic [7:0] exp_taken_znv = 8'b1110_1001;

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    drive(4'b0000, 3'b000, 9'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check("rst_pc", 32'(bus.pc), 32'h0000);
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_hlt", 32'(bus.hlt), 32'h0);
    check("rst_icount", bus.icount, 32'd0);

    step(); check("seq_pc1", 32'(bus.pc), 32'h0002);
    step(); check("seq_pc2", 32'(bus.pc), 32'h0004);
    step(); check("seq_pc3", 32'(bus.pc), 32'h0006);
    check("seq_icount", bus.icount, 32'd3);
    check("seq_hlt", 32'(bus.hlt), 32'h0);

    // BR to 0x0010 while writing Z=1
    drive(4'b1101, 3'b111, 9'h000, 16'h0010, 3'b100, 1'b1, 1'b0, 1'b0);
    step();
    check("br10_pc", 32'(bus.pc), 32'h0010);
    check("zset_flags", 32'(bus.flags), 32'h4);
    drive(4'b1100, 3'b001, 9'h1FC, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    check("beq_z1_pcplus", 32'(bus.pc_plus), 32'h0012);
    check("beq_z1_taken", 32'(bus.taken), 32'h1);
    step();
    check("beq_z1_pc", 32'(bus.pc), 32'h000A);

    // Same branch with Z cleared
    drive(4'b1101, 3'b111, 9'h000, 16'h0010, 3'b100, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b1100, 3'b001, 9'h1FC, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    check("beq_z0_taken", 32'(bus.taken), 32'h0);
    step();
    check("beq_z0_pc", 32'(bus.pc), 32'h0012);

    drive(4'b1101, 3'b111, 9'h000, 16'h1234, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    check("br_taken", 32'(bus.taken), 32'h1);
    step();
    check("br_pc", 32'(bus.pc), 32'h1234);

    drive(4'b1101, 3'b111, 9'h000, 16'hFFFE, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    check("brfffe_pc", 32'(bus.pc), 32'hFFFE);
    drive(4'b1100, 3'b111, 9'h001, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    check("wrap_pcplus", 32'(bus.pc_plus), 32'h0000);
    step();
    check("wrap_pc", 32'(bus.pc), 32'h0002);

    // Z: 0 -> 1 in the same cycle as BEQ; branch sees the old Z
    drive(4'b1100, 3'b001, 9'h010, 16'h0000, 3'b100, 1'b1, 1'b0, 1'b0);
    #1;
    check("oldz_taken", 32'(bus.taken), 32'h0);
    step();
    check("oldz_pc", 32'(bus.pc), 32'h0004);
    check("oldz_flags", 32'(bus.flags), 32'h4);

    drive(4'b0000, 3'b000, 9'h000, 16'h0000, 3'b111, 1'b0, 1'b1, 1'b1);
    step();
    check("znv_flags", 32'(bus.flags), 32'h3);
    check("znv_pc", 32'(bus.pc), 32'h0006);
    for (int c = 0; c < 8; c++) begin
      drive(4'b1100, 3'(c), 9'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("cond%0d_taken", c), 32'(bus.taken), 32'(exp_taken_znv[c]));
    end
    check("pre_hlt_icount", bus.icount, 32'd12);

    // HLT held off by stall
    bus.stall = 1'b1;
    drive(4'b1111, 3'b000, 9'h000, 16'h0000, 3'b111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_pc", i), 32'(bus.pc), 32'h0006);
      check($sformatf("stall%0d_icount", i), bus.icount, 32'd12);
      check($sformatf("stall%0d_hlt", i), 32'(bus.hlt), 32'h0);
    end
    check("stall_flags", 32'(bus.flags), 32'h3);
    bus.stall = 1'b0;
    drive(4'b1111, 3'b000, 9'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    check("hlt_hlt", 32'(bus.hlt), 32'h1);
    check("hlt_pc", 32'(bus.pc), 32'h0006);
    check("hlt_icount", bus.icount, 32'd13);

    drive(4'b1101, 3'b111, 9'h000, 16'h1234, 3'b111, 1'b1, 1'b0, 1'b0);
    #1;
    check("halted_taken", 32'(bus.taken), 32'h0);
    step();
    step();
    check("halted_pc", 32'(bus.pc), 32'h0006);
    check("halted_icount", bus.icount, 32'd13);
    check("halted_flags", 32'(bus.flags), 32'h3);
    check("halted_hlt", 32'(bus.hlt), 32'h1);

    // Reset wins over both HALTED and stall
    rst = 1'b1;
    bus.stall = 1'b1;
    step();
    check("rst2_pc", 32'(bus.pc), 32'h0000);
    check("rst2_hlt", 32'(bus.hlt), 32'h0);
    check("rst2_flags", 32'(bus.flags), 32'h0);
    check("rst2_icount", bus.icount, 32'd0);
    rst = 1'b0;
    bus.stall = 1'b0;
    drive(4'b0000, 3'b000, 9'h000, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    check("run_again_pc", 32'(bus.pc), 32'h0002);
    check("run_again_icount", bus.icount, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_ctrl_unit.md
# pc_ctrl_unit

Parametrised program-counter and branch-resolution unit for the WISC CPU datapath. It holds the PC, flag and halt state, and retired-instruction count. It evaluates B/BR conditions against registered Z/N/V flags and computes the next PC. It supports pipeline stall and a halt state machine. It sits between instruction memory (driven by `pc`) and the ALU/register file (supplying flags and rs data).

## Interface
Parameters:
- ADDR_W, 16, PC/address width
- IMM_W, 9, signed branch-offset width
- INC, 2, PC increment per instruction, in bytes
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  1 = hold all state this cycle
- opcode  in  4  decoded instruction opcode
- cond  in  3  branch condition field, instr[11:9]
- imm  in  IMM_W  signed branch offset, instr[8:0]
- rs_data  in  ADDR_W  rs register value, the BR target
- flag_wen  in  3  per-flag write enable {Z,N,V}
- z_in, n_in, v_in  in  1 each  flag values from the ALU
- pc  out  ADDR_W  current PC, registered
- pc_plus  out  ADDR_W  pc + INC, combinational, used by PCS
- taken  out  1  branch taken this cycle, combinational
- flags  out  3  registered {Z,N,V}
- hlt  out  1  registered; 1 = halted
- icount  out  CNT_W  retired-instruction count, registered

## Operation
- States: RUN, HALTED. Reset → RUN.
- Active edge means: state RUN and stall=0.
- B is opcode 4'b1100. Target = pc + INC + (sext(imm) << 1). All arithmetic is mod 2^ADDR_W, so the target wraps.
- BR is opcode 4'b1101. Target = rs_data, used as-is with no alignment forcing.
- Condition codes, using registered flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1, or Z=0 and N=0
  - 101 LE: Z=1 or N=1
  - 110 OV: V=1
  - 111 unconditional
- taken = (opcode is B or BR) and condition met and state RUN. taken is independent of stall.
- Next PC on an active edge:
  - taken B → B target
  - taken BR → BR target
  - HLT (4'b1111) → pc unchanged
  - otherwise → pc_plus
- HLT on an active edge: state → HALTED and hlt → 1. pc stays at the HLT address. icount increments once for the HLT itself.
- HALTED is absorbing until rst. pc, flags and icount are frozen; all inputs are ignored.
- Flags: on an active edge, each flag whose flag_wen bit is 1 loads its input; other flags hold. Branches always see the pre-edge flag value. A simultaneous flag write and branch evaluation is legal.
- icount: +1 on every active edge and wraps at 2^CNT_W.
- stall=1: pc, flags, icount and state all hold. A HLT under stall takes effect on the first unstalled cycle.

## Timing
- Reset values: pc=RESET_PC, flags=3'b000, hlt=0, icount=0, state=RUN.
- rst has priority over stall and over the HALTED state. Reset mid-halt or mid-stall returns to RUN on the next edge.
- Latency:
  - taken and pc_plus are valid in the same cycle as their inputs.
  - pc and flags reflect an instruction one edge later.
  - hlt rises on the edge that consumes the HLT and stays high.
- No handshake. The caller holds opcode/cond/imm/rs_data stable for the whole cycle; stall gates acceptance.

## Test plan
- Reset, then 3 non-branch opcodes (e.g. 4'b0000) → pc 0→2→4→6, icount=3, hlt=0.
- flags set to Z=1 via flag_wen=100 at pc=0x0010, then B cond=001 imm=9'h1FC (−4) → taken=1, pc = 0x0012 − 8 = 0x000A. Same stimulus with Z=0 → taken=0, pc=0x0012.
- BR cond=111 with rs_data=0x1234 → pc=0x1234 after one edge. B at pc=0xFFFE with imm=+1 → pc wraps to 0x0002.
- Same-cycle flag write (Z: 0→1) with B cond=001 → not taken, since the old Z is used. Z reads 1 afterwards.
- stall=1 for 3 cycles with HLT presented → pc, icount and hlt unchanged. Drop stall → hlt=1 next edge, pc = HLT address, icount +1. Further opcodes, including BR with cond=111 → taken=0, pc frozen.
- rst asserted while HALTED with stall=1 → next edge: pc=RESET_PC, hlt=0, flags=0, icount=0, RUN.
